// File: rtl/nn_pkg.sv
// nn_pkg: serializer FSM states and index-width helper.
package nn_pkg;
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/nn_argmax_acc.sv
// nn_argmax_acc: running signed maximum over a beat stream, lowest index wins ties.
module nn_argmax_acc #(
    parameter int W  = 16,
    parameter int IW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          update,
    input  logic [W-1:0]  din,
    input  logic [IW-1:0] idx_in,
    output logic [W-1:0]  max,
    output logic [IW-1:0] idx
);
    logic take;
    // the first beat always seeds the maximum; strict > keeps the earlier index on ties
    assign take = update && (idx_in == '0 || $signed(din) > $signed(max));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max <= '0;
            idx <= '0;
        end else if (clear) begin
            max <= {1'b1, {(W-1){1'b0}}};
            idx <= '0;
        end else if (take) begin
            max <= din;
            idx <= idx_in;
        end
    end
endmodule

// File: rtl/nn_layer_serializer.sv
// nn_layer_serializer: captures a parallel layer frame and streams it one word per beat.
// Optional running argmax compiled in with ARGMAX_EN.
module nn_layer_serializer
    import nn_pkg::*;
#(
    parameter int NUM_NEURONS = 30,
    parameter int data_width  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS*data_width-1:0] layer_in,
    input  logic [NUM_NEURONS-1:0]            in_valid,
    output logic [data_width-1:0]             out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic                              busy,
    output logic                              overrun,
    output logic [$clog2(NUM_NEURONS)-1:0]    class_idx,
    output logic                              class_valid
);
    localparam int IW = idx_w(NUM_NEURONS);

    state_t                state, state_nxt;
    logic [IW-1:0]         idx;
    logic                  and_q, frame_start, capture, xfer, last;
    logic [data_width-1:0] buf_q [NUM_NEURONS];

    assign frame_start = (&in_valid) && !and_q;
    assign capture     = (state == IDLE) && frame_start;
    assign last        = idx == IW'(NUM_NEURONS - 1);
    assign out_valid   = state == STREAM;
    assign xfer        = out_valid && out_ready;
    assign out_last    = out_valid && last;
    assign out_data    = out_valid ? buf_q[idx] : '0;
    assign busy        = state != IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (capture)                          state_nxt = STREAM;
        else if (state == STREAM && xfer && last) state_nxt = DONE;
        else if (state == DONE)               state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            and_q   <= 1'b0;
            idx     <= '0;
            overrun <= 1'b0;
        end else begin
            and_q <= &in_valid;
            if (capture)           idx <= '0;
            else if (xfer && !last) idx <= idx + 1'b1;
            if (frame_start && state != IDLE) overrun <= 1'b1;
        end
    end

    // buffer contents need no reset; they are only observed in STREAM
    always_ff @(posedge clk) begin
        if (capture)
            for (int i = 0; i < NUM_NEURONS; i++)
                buf_q[i] <= layer_in[i*data_width +: data_width];
    end

`ifdef ARGMAX_EN
    logic [data_width-1:0] acc_max;
    logic [IW-1:0]         acc_idx;

    nn_argmax_acc #(.W(data_width), .IW(IW)) u_argmax (
        .clk    (clk),
        .rst    (rst),
        .clear  (capture),
        .update (xfer),
        .din    (out_data),
        .idx_in (idx),
        .max    (acc_max),
        .idx    (acc_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            class_idx   <= '0;
            class_valid <= 1'b0;
        end else begin
            class_valid <= state == DONE;
            if (state == DONE) class_idx <= acc_idx;
        end
    end
`else
    assign class_idx   = '0;
    assign class_valid = 1'b0;
`endif
endmodule

// File: doc/nn_layer_serializer.md
NN_LAYER_SERIALIZER -- requirements
Module: nn_layer_serializer

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 30: number of parallel neuron results captured per frame.
REQ-002 SHALL have parameter data_width, default 16: width of each signed two's-complement neuron result.
REQ-003 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port layer_in, input, NUM_NEURONS x data_width: parallel neuron outputs from the upstream layer.
REQ-006 SHALL have port in_valid, input, NUM_NEURONS: per-neuron valid flags from the upstream layer.
REQ-007 SHALL have port out_data, output, data_width: serial result stream toward the next layer.
REQ-008 SHALL have port out_valid, output, 1: out_data holds a beat.
REQ-009 SHALL have port out_ready, input, 1: downstream accepts a beat.
REQ-010 SHALL have port out_last, output, 1: current beat is neuron NUM_NEURONS-1.
REQ-011 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-012 SHALL have port overrun, output, 1: sticky flag, frame dropped while busy.
REQ-013 SHALL have port class_idx, output, $clog2(NUM_NEURONS): argmax index of the last frame.
REQ-014 SHALL have port class_valid, output, 1: one-cycle pulse when class_idx updates.

Function
REQ-015 SHALL define frame_start as the rising edge of AND(in_valid), using a registered copy of AND(in_valid).
REQ-016 SHALL use states IDLE, STREAM, DONE.
REQ-017 SHALL, on frame_start in IDLE, register all layer_in words into a NUM_NEURONS-deep buffer, clear the index to 0 and enter STREAM on the next edge.
REQ-018 SHALL, in STREAM, drive out_valid=1 and out_data=buf[idx]; out_last=1 when idx==NUM_NEURONS-1.
REQ-019 SHALL transfer a beat only when out_valid && out_ready; idx increments on each transfer.
REQ-020 SHALL hold out_data and out_last stable while out_valid && !out_ready.
REQ-021 SHALL enter DONE on transfer of the last beat; DONE lasts exactly one cycle, then returns to IDLE.
REQ-022 SHALL make the first beat available one cycle after the frame_start edge; with out_ready held high, a frame completes in NUM_NEURONS+2 cycles from capture to IDLE.
REQ-023 SHALL ignore a frame_start occurring outside IDLE (no recapture) and set overrun to 1; overrun clears only on reset.
REQ-024 SHALL ignore a frame_start coinciding with the DONE cycle and set overrun.
REQ-025 SHALL never wrap idx past NUM_NEURONS-1.

Reset
REQ-026 SHALL, on rst low, immediately force: state IDLE, idx 0, out_valid 0, out_last 0, out_data 0, busy 0, overrun 0, class_idx 0, class_valid 0, and registered AND(in_valid) 0.
REQ-027 SHALL abort a frame mid-STREAM on reset without emitting further beats.
REQ-028 SHALL not require buffer contents to be reset.

Configuration
REQ-029 SHALL compile in a running argmax when ARGMAX_EN is defined.
REQ-030 With ARGMAX_EN: SHALL signed-compare each transferred beat against the running maximum, keeping the lowest index on ties.
REQ-031 With ARGMAX_EN: SHALL update class_idx and pulse class_valid in DONE.
REQ-032 Without ARGMAX_EN: SHALL hold class_idx at 0 and class_valid at 0, with no compare logic present.

Structure
REQ-033 SHALL place the state enum and an index-width helper function in shared package nn_pkg.
REQ-034 SHALL implement the argmax in one sub-module, nn_argmax_acc (clear/update/max/idx), instantiated only under ARGMAX_EN.

Verification
REQ-035 SHALL verify, with NUM_NEURONS=4, layer_in={5,-3,9,2} (index 0 first), all in_valid rising and out_ready=1: beats 5,-3,9,2 on consecutive cycles, out_last on beat 4, class_idx=2 with class_valid for one cycle.
REQ-036 SHALL verify that out_ready=0 for 3 cycles on beat 2 holds out_data=-3 stable, and the frame then completes with no lost or duplicated beats.
REQ-037 SHALL verify that in_valid dropping and rising again during STREAM sets overrun=1 and leaves the stream unchanged (5,-3,9,2).
REQ-038 SHALL verify that inputs {-7,-7,-8,-9} give class_idx=0 (tie and all-negative case).
REQ-039 SHALL verify that rst asserted low after beat 2 forces out_valid=0, busy=0, overrun=0 asynchronously, and that a new frame {1,2,3,4} then streams correctly.
REQ-040 SHALL verify that a build without ARGMAX_EN streams identically with class_valid never asserted.
